time_set_controller: RTL and testbench

//  Operator-input side of the digital clock: writes time and alarm values that the display path reads.

---
 rtl/time_set_controller_pkg.sv | 34 +++
 rtl/time_set_controller_if.sv | 28 ++
 rtl/time_set_controller_button_debounce.sv | 83 ++++++++
 rtl/time_set_controller.sv | 130 +++++++++++++
 tb/tb_time_set_controller.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/time_set_controller_pkg.sv
// Shared encodings, field limits and timing helpers for the time/alarm setting path.
// Pure definitions: no latency, no flow control.
package time_set_controller_pkg;

    localparam int STATE_W = 3;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int FIELD_W = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN    = 3'd0,
        ST_T_HOUR = 3'd1,
        ST_T_MIN  = 3'd2,
        ST_A_HOUR = 3'd3,
        ST_A_MIN  = 3'd4
    } edit_state_e;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    function automatic longint ms_to_cycles(input longint clk_hz, input longint ms);
        return (clk_hz * ms) / 64'sd1000;
    endfunction

    // Modular +/-1 over 0..max; out-of-range values snap back into range.
    function automatic logic [FIELD_W-1:0] wrap_step(input logic [FIELD_W-1:0] val,
                                                     input logic [FIELD_W-1:0] max,
                                                     input logic               up);
        if (up)
            return (val >= max) ? '0 : val + FIELD_W'(1);
        return (val == '0 || val > max) ? max : val - FIELD_W'(1);
    endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Button, live-time and set/alarm signals between the operator logic and the clock datapath.
// Wires only: no latency, no flow control.
interface time_set_controller_if;
    import time_set_controller_pkg::*;

    logic                btn_mode;
    logic                btn_inc;
    logic                btn_dec;
    logic [HOUR_W-1:0]   cur_hour;
    logic [MIN_W-1:0]    cur_min;
    logic                set_time_vld;
    logic [HOUR_W-1:0]   set_hour;
    logic [MIN_W-1:0]    set_min;
    logic [HOUR_W-1:0]   alarm_hour;
    logic [MIN_W-1:0]    alarm_min;
    logic [STATE_W-1:0]  edit_state;

    modport master (
        input  btn_mode, btn_inc, btn_dec, cur_hour, cur_min,
        output set_time_vld, set_hour, set_min, alarm_hour, alarm_min, edit_state
    );

    modport slave (
        output btn_mode, btn_inc, btn_dec, cur_hour, cur_min,
        input  set_time_vld, set_hour, set_min, alarm_hour, alarm_min, edit_state
    );

endinterface

// File: rtl/time_set_controller_button_debounce.sv
// Button conditioner: 2-FF sync, debounce, one-cycle press on the accepted rising level, optional auto-repeat.
// Latency: 2 sync + DB_CYC cycles to press; no backpressure, presses are fire-and-forget pulses.
module button_debounce #(
    parameter longint DB_CYC        = 64'sd4,
    parameter longint RPT_START_CYC = 64'sd20,
    parameter longint RPT_CYC       = 64'sd5,
    parameter bit     RPT_EN        = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_press
);

    localparam int DB_W  = $clog2(DB_CYC + 64'sd1);
    localparam int RPT_W = $clog2(RPT_START_CYC + RPT_CYC + 64'sd1);
    localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYC - 64'sd1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(RPT_START_CYC - 64'sd1);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(RPT_CYC - 64'sd1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic             r_rpt_on;
    logic [DB_W-1:0]  r_db_cnt;
    logic [RPT_W-1:0] r_rpt_cnt;
    logic             w_flip;

    assign w_flip  = (r_sync2 != r_level) && (r_db_cnt == DB_LAST);
    assign o_press = r_press;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_db_cnt <= '0;
            end else if (w_flip) begin
                r_db_cnt <= '0;
                r_level  <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    // Repeat timer runs only while the accepted level stays high; a level change restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_press   <= 1'b0;
            r_rpt_on  <= 1'b0;
            r_rpt_cnt <= '0;
        end else begin
            r_press <= 1'b0;
            if (w_flip) begin
                r_press   <= r_sync2;
                r_rpt_on  <= 1'b0;
                r_rpt_cnt <= '0;
            end else if (RPT_EN && r_level) begin
                if (!r_rpt_on && r_rpt_cnt == RPT_FIRST) begin
                    r_press   <= 1'b1;
                    r_rpt_on  <= 1'b1;
                    r_rpt_cnt <= '0;
                end else if (r_rpt_on && r_rpt_cnt == RPT_NEXT) begin
                    r_press   <= 1'b1;
                    r_rpt_cnt <= '0;
                end else begin
                    r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                end
            end else begin
                r_rpt_on  <= 1'b0;
                r_rpt_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Operator edit FSM for time and alarm: debounced buttons step hour/minute fields, strobe time loads, hold alarm.
// Latency: press -> state/field 1 cycle, set_time_vld combinational on the commit cycle; no backpressure.
module time_set_controller
    import time_set_controller_pkg::*;
#(
    parameter longint            CLK_HZ          = 64'sd100_000_000,
    parameter longint            DEBOUNCE_MS     = 64'sd20,
    parameter longint            REPEAT_START_MS = 64'sd500,
    parameter longint            REPEAT_MS       = 64'sd150,
    parameter longint            TIMEOUT_S       = 64'sd30,
    parameter logic [HOUR_W-1:0] ALARM_H_RST     = 5'd14,
    parameter logic [MIN_W-1:0]  ALARM_M_RST     = 6'd8
) (
    input  logic                  clk,
    input  logic                  reset,
    time_set_controller_if.master bus
);

    localparam longint DB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam longint RS_CYC = ms_to_cycles(CLK_HZ, REPEAT_START_MS);
    localparam longint RP_CYC = ms_to_cycles(CLK_HZ, REPEAT_MS);
    localparam longint TO_CYC = ms_to_cycles(CLK_HZ, TIMEOUT_S * 64'sd1000);
    localparam int     TO_W   = $clog2(TO_CYC + 64'sd1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 64'sd1);

    edit_state_e       r_state;
    edit_state_e       w_state_nxt;
    logic [HOUR_W-1:0] r_set_hour;
    logic [HOUR_W-1:0] w_set_hour_nxt;
    logic [MIN_W-1:0]  r_set_min;
    logic [MIN_W-1:0]  w_set_min_nxt;
    logic [HOUR_W-1:0] r_alarm_hour;
    logic [HOUR_W-1:0] w_alarm_hour_nxt;
    logic [MIN_W-1:0]  r_alarm_min;
    logic [MIN_W-1:0]  w_alarm_min_nxt;
    logic [TO_W-1:0]   r_idle;
    logic              w_mode;
    logic              w_inc;
    logic              w_dec;
    logic              w_any;
    logic              w_up;
    logic              w_dn;
    logic              w_timeout;
    logic              w_set_vld;

    button_debounce #(.DB_CYC(DB_CYC), .RPT_START_CYC(RS_CYC), .RPT_CYC(RP_CYC), .RPT_EN(1'b0))
        u_db_mode (.clk(clk), .reset(reset), .i_btn(bus.btn_mode), .o_press(w_mode));
    button_debounce #(.DB_CYC(DB_CYC), .RPT_START_CYC(RS_CYC), .RPT_CYC(RP_CYC), .RPT_EN(1'b1))
        u_db_inc  (.clk(clk), .reset(reset), .i_btn(bus.btn_inc),  .o_press(w_inc));
    button_debounce #(.DB_CYC(DB_CYC), .RPT_START_CYC(RS_CYC), .RPT_CYC(RP_CYC), .RPT_EN(1'b1))
        u_db_dec  (.clk(clk), .reset(reset), .i_btn(bus.btn_dec),  .o_press(w_dec));

    // Mode outranks the steppers; opposing steps in the same cycle cancel.
    assign w_any     = w_mode | w_inc | w_dec;
    assign w_up      = w_inc & ~w_dec & ~w_mode;
    assign w_dn      = w_dec & ~w_inc & ~w_mode;
    assign w_timeout = (r_state != ST_RUN) && !w_any && (r_idle == TO_LAST);

    always_comb begin
        w_state_nxt      = r_state;
        w_set_hour_nxt   = r_set_hour;
        w_set_min_nxt    = r_set_min;
        w_alarm_hour_nxt = r_alarm_hour;
        w_alarm_min_nxt  = r_alarm_min;
        w_set_vld        = 1'b0;
        if (w_timeout) begin
            w_state_nxt = ST_RUN;
        end else if (w_mode) begin
            case (r_state)
                ST_RUN: begin
                    w_state_nxt    = ST_T_HOUR;
                    w_set_hour_nxt = bus.cur_hour;
                    w_set_min_nxt  = bus.cur_min;
                end
                ST_T_HOUR: w_state_nxt = ST_T_MIN;
                ST_T_MIN: begin
                    // Strobe while set_hour/set_min still show the edited time.
                    w_state_nxt    = ST_A_HOUR;
                    w_set_vld      = 1'b1;
                    w_set_hour_nxt = r_alarm_hour;
                    w_set_min_nxt  = r_alarm_min;
                end
                ST_A_HOUR: w_state_nxt = ST_A_MIN;
                ST_A_MIN: begin
                    w_state_nxt      = ST_RUN;
                    w_alarm_hour_nxt = r_set_hour;
                    w_alarm_min_nxt  = r_set_min;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end else if (w_up || w_dn) begin
            case (r_state)
                ST_T_HOUR, ST_A_HOUR:
                    w_set_hour_nxt = HOUR_W'(wrap_step(FIELD_W'(r_set_hour), FIELD_W'(HOUR_MAX), w_up));
                ST_T_MIN, ST_A_MIN:
                    w_set_min_nxt = MIN_W'(wrap_step(FIELD_W'(r_set_min), FIELD_W'(MIN_MAX), w_up));
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_set_hour   <= '0;
            r_set_min    <= '0;
            r_alarm_hour <= ALARM_H_RST;
            r_alarm_min  <= ALARM_M_RST;
            r_idle       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_set_hour   <= w_set_hour_nxt;
            r_set_min    <= w_set_min_nxt;
            r_alarm_hour <= w_alarm_hour_nxt;
            r_alarm_min  <= w_alarm_min_nxt;
            if (r_state == ST_RUN || w_any || w_timeout)
                r_idle <= '0;
            else
                r_idle <= r_idle + TO_W'(1);
        end
    end

    assign bus.set_time_vld = w_set_vld;
    assign bus.set_hour     = r_set_hour;
    assign bus.set_min      = r_set_min;
    assign bus.alarm_hour   = r_alarm_hour;
    assign bus.alarm_min    = r_alarm_min;
    assign bus.edit_state   = r_state;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller at 1 cycle per ms: edit flow, wraps, bounce, repeat, timeout, reset.
module tb_time_set_controller;

    logic clk = 1'b0;
    logic reset;
    int   n_vec   = 0;
    int   n_fail  = 0;
    int   vld_cnt = 0;
    logic [4:0] cap_h = '0;
    logic [5:0] cap_m = '0;

    time_set_controller_if u_if ();

    time_set_controller #(
        .CLK_HZ          (64'sd1000),
        .DEBOUNCE_MS     (64'sd4),
        .REPEAT_START_MS (64'sd20),
        .REPEAT_MS       (64'sd5),
        .TIMEOUT_S       (64'sd1),
        .ALARM_H_RST     (5'd14),
        .ALARM_M_RST     (6'd8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.set_time_vld === 1'b1) begin
            vld_cnt++;
            cap_h = u_if.set_hour;
            cap_m = u_if.set_min;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic m, input logic i, input logic d);
        u_if.btn_mode = m;
        u_if.btn_inc  = i;
        u_if.btn_dec  = d;
        tick(8);
        u_if.btn_mode = 1'b0;
        u_if.btn_inc  = 1'b0;
        u_if.btn_dec  = 1'b0;
        tick(8);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        u_if.btn_mode = 1'b0;
        u_if.btn_inc  = 1'b0;
        u_if.btn_dec  = 1'b0;
        u_if.cur_hour = 5'd14;
        u_if.cur_min  = 6'd7;
        #1 reset = 1'b0;
        tick(3);
        check("rst_state", 32'(u_if.edit_state), 0);
        check("rst_vld",   32'(u_if.set_time_vld), 0);
        check("rst_set_h", 32'(u_if.set_hour), 0);
        check("rst_set_m", 32'(u_if.set_min), 0);
        check("rst_alm_h", 32'(u_if.alarm_hour), 14);
        check("rst_alm_m", 32'(u_if.alarm_min), 8);
        reset = 1'b1;
        tick(4);

        // Full time edit from 14:07 to 17:59
        push(1, 0, 0);
        check("enter_state", 32'(u_if.edit_state), 1);
        check("enter_h", 32'(u_if.set_hour), 14);
        check("enter_m", 32'(u_if.set_min), 7);
        repeat (3) push(0, 1, 0);
        check("hour_inc3", 32'(u_if.set_hour), 17);
        push(1, 0, 0);
        check("t_min_state", 32'(u_if.edit_state), 2);
        repeat (8) push(0, 0, 1);
        check("min_dec8_wrap", 32'(u_if.set_min), 59);
        push(0, 1, 0);
        check("min_59_inc", 32'(u_if.set_min), 0);
        push(0, 0, 1);
        check("min_0_dec", 32'(u_if.set_min), 59);
        check("no_vld_yet", 32'(vld_cnt), 0);
        push(1, 0, 0);
        check("commit_vld_cnt", 32'(vld_cnt), 1);
        check("commit_h", 32'(cap_h), 17);
        check("commit_m", 32'(cap_m), 59);
        check("a_hour_state", 32'(u_if.edit_state), 3);
        check("a_hour_load_h", 32'(u_if.set_hour), 14);
        check("a_hour_load_m", 32'(u_if.set_min), 8);

        // Hour wraps, then alarm 06:30
        repeat (9) push(0, 1, 0);
        check("hour_to_23", 32'(u_if.set_hour), 23);
        push(0, 1, 0);
        check("hour_23_inc", 32'(u_if.set_hour), 0);
        push(0, 0, 1);
        check("hour_0_dec", 32'(u_if.set_hour), 23);
        repeat (7) push(0, 1, 0);
        check("alarm_h_6", 32'(u_if.set_hour), 6);
        push(1, 0, 0);
        check("a_min_state", 32'(u_if.edit_state), 4);
        repeat (22) push(0, 1, 0);
        check("alarm_m_30", 32'(u_if.set_min), 30);
        check("alarm_m_uncommitted", 32'(u_if.alarm_min), 8);
        push(1, 0, 0);
        check("alarm_commit_state", 32'(u_if.edit_state), 0);
        check("alarm_commit_h", 32'(u_if.alarm_hour), 6);
        check("alarm_commit_m", 32'(u_if.alarm_min), 30);
        check("alarm_commit_no_vld", 32'(vld_cnt), 1);

        push(0, 1, 0);
        check("run_inc_state", 32'(u_if.edit_state), 0);
        check("run_inc_h", 32'(u_if.set_hour), 6);
        check("run_inc_m", 32'(u_if.set_min), 30);

        // Bouncy inc in T_HOUR
        u_if.cur_hour = 5'd9;
        u_if.cur_min  = 6'd10;
        push(1, 0, 0);
        check("bounce_enter_h", 32'(u_if.set_hour), 9);
        for (int i = 0; i < 10; i++) begin
            u_if.btn_inc = ((i % 4) < 2);
            tick(1);
        end
        tick(16);
        check("bounce_single", 32'(u_if.set_hour), 10);
        u_if.btn_inc = 1'b0;
        tick(10);
        check("bounce_settled", 32'(u_if.set_hour), 10);

        // Auto-repeat in T_MIN from 10
        push(1, 0, 0);
        check("rpt_enter_m", 32'(u_if.set_min), 10);
        u_if.btn_inc = 1'b1;
        tick(15);
        check("rpt_first", 32'(u_if.set_min), 11);
        tick(13);
        check("rpt_second", 32'(u_if.set_min), 12);
        tick(10);
        u_if.btn_inc = 1'b0;
        tick(12);
        check("rpt_final", 32'(u_if.set_min), 15);

        push(1, 0, 0);
        check("commit2_vld_cnt", 32'(vld_cnt), 2);
        check("commit2_h", 32'(cap_h), 10);
        check("commit2_m", 32'(cap_m), 15);
        check("a_hour_alarm_h", 32'(u_if.set_hour), 6);

        // Idle timeout in A_MIN
        push(1, 0, 0);
        check("to_a_min", 32'(u_if.edit_state), 4);
        tick(900);
        check("to_not_yet", 32'(u_if.edit_state), 4);
        tick(200);
        check("to_run", 32'(u_if.edit_state), 0);
        check("to_alarm_h", 32'(u_if.alarm_hour), 6);
        check("to_alarm_m", 32'(u_if.alarm_min), 30);
        check("to_no_vld", 32'(vld_cnt), 2);

        // Simultaneous presses
        u_if.cur_hour = 5'd5;
        u_if.cur_min  = 6'd45;
        push(1, 1, 0);
        check("mode_wins_state", 32'(u_if.edit_state), 1);
        check("mode_wins_h", 32'(u_if.set_hour), 5);
        push(0, 1, 1);
        check("inc_dec_dropped", 32'(u_if.set_hour), 5);
        push(0, 0, 1);
        check("dec_alone", 32'(u_if.set_hour), 4);

        // Asynchronous reset mid-edit
        reset = 1'b0;
        #1;
        check("arst_state", 32'(u_if.edit_state), 0);
        check("arst_set_h", 32'(u_if.set_hour), 0);
        check("arst_set_m", 32'(u_if.set_min), 0);
        check("arst_alm_h", 32'(u_if.alarm_hour), 14);
        check("arst_alm_m", 32'(u_if.alarm_min), 8);
        check("arst_vld", 32'(u_if.set_time_vld), 0);
        tick(2);
        reset = 1'b1;
        tick(5);
        check("arst_no_strobe", 32'(vld_cnt), 2);
        check("arst_stays_run", 32'(u_if.edit_state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
